// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM-stage load/store unit (master) and data_mem_ctrl (slave).
interface data_mem_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rvalid, rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rvalid, rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with sequential init engine, byte-enable writes and registered read.
// Optional per-byte even parity with error reporting is enabled by defining MEM_PARITY_EN.
//   state   | meaning
//   ST_INIT | writing pattern(init_cnt) to mem[init_cnt], one word per clk; requests refused
//   ST_RUN  | accepting requests; init_req restarts initialisation
module data_mem_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int INIT_MODE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic init_req,
  output logic init_done,
`ifdef MEM_PARITY_EN
  input  logic par_inject,
  output logic par_err,
`endif
  data_mem_ctrl_if.slave bus
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   init_cnt_q, init_cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                rvalid_q, rvalid_d;
  logic                init_done_q, init_done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                acc, wr_acc, rd_acc;
  logic [DATA_W-1:0]   init_word;

  assign acc       = bus.req_valid & req_ready_q;
  assign wr_acc    = acc & bus.req_we;
  assign rd_acc    = acc & ~bus.req_we;
  assign init_word = (INIT_MODE == 1) ? DATA_W'(init_cnt_q) : '0;

`ifdef MEM_PARITY_EN
  logic [NB-1:0]       par_mem [DEPTH];
  logic                par_err_q, par_err_d;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int k = 0; k < NB; k++) p[k] = ^w[8*k +: 8];
    return p;
  endfunction

  assign par_err_d = rd_acc & (|(byte_par(mem[bus.req_addr]) ^ par_mem[bus.req_addr]));
  assign par_err   = par_err_q;
`endif

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    req_ready_d = req_ready_q;
    init_done_d = init_done_q;
    rvalid_d    = rd_acc;
    rdata_d     = rd_acc ? mem[bus.req_addr] : rdata_q;
    unique case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == {ADDR_W{1'b1}}) begin
          state_d     = ST_RUN;
          init_cnt_d  = '0;
          req_ready_d = 1'b1;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        // a request in this same clk is still accepted; ready drops from the next clk
        if (init_req) begin
          state_d     = ST_INIT;
          init_cnt_d  = '0;
          req_ready_d = 1'b0;
          init_done_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      rvalid_q    <= 1'b0;
      init_done_q <= 1'b0;
      rdata_q     <= '0;
`ifdef MEM_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      req_ready_q <= req_ready_d;
      rvalid_q    <= rvalid_d;
      init_done_q <= init_done_d;
      rdata_q     <= rdata_d;
`ifdef MEM_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // storage carries no reset; contents are rebuilt by the init engine
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_cnt_q] <= init_word;
`ifdef MEM_PARITY_EN
      par_mem[init_cnt_q] <= byte_par(init_word);
`endif
    end else if (wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (bus.req_be[k]) begin
          mem[bus.req_addr][8*k +: 8] <= bus.req_wdata[8*k +: 8];
`ifdef MEM_PARITY_EN
          par_mem[bus.req_addr][k] <= (^bus.req_wdata[8*k +: 8]) ^ par_inject;
`endif
        end
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (DATA_W=16, ADDR_W=10, INIT_MODE=1); parity cases when MEM_PARITY_EN is defined.
module tb_data_mem_ctrl;

  logic clk;
  logic reset;
  logic init_req;
  logic init_done;
`ifdef MEM_PARITY_EN
  logic par_inject;
  logic par_err;
`endif

  int n_checks;
  int n_fail;

  data_mem_ctrl_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  data_mem_ctrl #(.DATA_W(16), .ADDR_W(10), .INIT_MODE(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .init_req   (init_req),
    .init_done  (init_done),
`ifdef MEM_PARITY_EN
    .par_inject (par_inject),
    .par_err    (par_err),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // counts clks until init_done; optionally pulses init_req plus a stray write mid-init
  task automatic wait_init(input int pulse_at, output int n, output int early_ready);
    n = 0;
    early_ready = 0;
    while (init_done !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (bus.req_ready && !init_done) early_ready++;
      if (n == pulse_at) begin
        init_req      = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 10'h030;
        bus.req_wdata = 16'hDEAD;
        bus.req_be    = 2'b11;
      end else begin
        init_req      = 1'b0;
        bus.req_valid = 1'b0;
      end
    end
  endtask

  task automatic do_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [9:0] a, input logic [15:0] exp);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_val({tag, "_rvalid"}, {31'd0, bus.rvalid}, 32'd1);
    check_val(tag, {16'd0, bus.rdata}, {16'd0, exp});
  endtask

  initial begin
    int n, early;
    logic [9:0]  rd_addr [4];
    logic [15:0] rd_exp  [4];
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    init_req = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
`ifdef MEM_PARITY_EN
    par_inject = 1'b0;
`endif
    #1;
    check_val("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check_val("rst_rdata", {16'd0, bus.rdata}, 32'd0);
    check_val("rst_init_done", {31'd0, init_done}, 32'd0);

    #21 reset = 1'b1;
    wait_init(0, n, early);
    check_val("init_clks", n, 32'd1024);
    check_val("init_ready_early", early, 32'd0);
    check_val("run_ready", {31'd0, bus.req_ready}, 32'd1);

    do_read("rd_005", 10'h005, 16'h0005);
    do_read("rd_3ff", 10'h3FF, 16'h03FF);

    do_write(10'h010, 16'hBEEF, 2'b11);
    check_val("wr_no_rvalid", {31'd0, bus.rvalid}, 32'd0);
    do_write(10'h010, 16'h1234, 2'b10);
    do_read("rd_be_hi", 10'h010, 16'h12EF);
    @(posedge clk); #1;
    check_val("rvalid_pulse", {31'd0, bus.rvalid}, 32'd0);
    check_val("rdata_hold", {16'd0, bus.rdata}, 32'h12EF);

    do_write(10'h005, 16'hFFFF, 2'b00);
    do_read("rd_be_none", 10'h005, 16'h0005);

    do_write(10'h020, 16'hA5A5, 2'b11);
    do_read("rd_after_wr", 10'h020, 16'hA5A5);

    rd_addr = '{10'h005, 10'h006, 10'h020, 10'h3FF};
    rd_exp  = '{16'h0005, 16'h0006, 16'hA5A5, 16'h03FF};
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = rd_addr[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_val($sformatf("b2b_rvalid%0d", i), {31'd0, bus.rvalid}, 32'd1);
      check_val($sformatf("b2b_rdata%0d", i), {16'd0, bus.rdata}, {16'd0, rd_exp[i]});
      if (i < 3) bus.req_addr = rd_addr[i+1];
      else bus.req_valid = 1'b0;
    end

    // init_req with a read in the same clk: the read is still served
    init_req      = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 10'h010;
    @(posedge clk); #1;
    init_req      = 1'b0;
    bus.req_valid = 1'b0;
    check_val("initreq_rd_rvalid", {31'd0, bus.rvalid}, 32'd1);
    check_val("initreq_rd_data", {16'd0, bus.rdata}, 32'h12EF);
    check_val("initreq_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("initreq_done", {31'd0, init_done}, 32'd0);
    wait_init(100, n, early);
    check_val("reinit_clks", n, 32'd1024);
    check_val("reinit_ready_early", early, 32'd0);
    do_read("rd_reinit_010", 10'h010, 16'h0010);
    do_read("rd_reinit_020", 10'h020, 16'h0020);
    do_read("rd_ignored_wr", 10'h030, 16'h0030);

    #3 reset = 1'b0;
    #1;
    check_val("rstrun_ready", {31'd0, bus.req_ready}, 32'd0);
    check_val("rstrun_rdata", {16'd0, bus.rdata}, 32'd0);
    check_val("rstrun_done", {31'd0, init_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (300) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_val("rstinit_done", {31'd0, init_done}, 32'd0);
    check_val("rstinit_ready", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_init(0, n, early);
    check_val("rst_reinit_clks", n, 32'd1024);
    do_read("rd_after_rst", 10'h3FF, 16'h03FF);

`ifdef MEM_PARITY_EN
    par_inject = 1'b1;
    do_write(10'h040, 16'h00FF, 2'b11);
    par_inject = 1'b0;
    do_read("rd_par_bad", 10'h040, 16'h00FF);
    check_val("par_err_set", {31'd0, par_err}, 32'd1);
    do_write(10'h040, 16'h00FF, 2'b11);
    do_read("rd_par_ok", 10'h040, 16'h00FF);
    check_val("par_err_clr", {31'd0, par_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
